// File: rtl/uart_rx_pkt_ctrl.sv
// rtl/uart_rx_pkt_ctrl.sv - sync/length/checksum packet receiver with buffered valid/ready drain
`timescale 1ns/1ps
module uart_rx_pkt_ctrl #(
    parameter logic [7:0] SYNC_BYTE    = 8'hA5,
    parameter int         MAX_LEN      = 16,
    parameter int         TIMEOUT_CLKS = 208320
) (
    input  logic       i_Clock,
    input  logic       reset,
    output logic       o_Receive,
    input  logic       i_Rx_DV,
    input  logic [7:0] i_Rx_Byte,
    output logic [7:0] o_Data,
    output logic       o_Valid,
    output logic       o_Last,
    input  logic       i_Ready,
    output logic [7:0] o_Pkt_Len,
    output logic       o_Busy,
    output logic       o_Err_Len,
    output logic       o_Err_Chk,
    output logic       o_Err_Timeout
);

    localparam logic [2:0] s_HUNT    = 3'd0;
    localparam logic [2:0] s_LEN     = 3'd1;
    localparam logic [2:0] s_PAYLOAD = 3'd2;
    localparam logic [2:0] s_CHK     = 3'd3;
    localparam logic [2:0] s_DRAIN   = 3'd4;

    localparam int          IW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [23:0] TO_LAST   = 24'(TIMEOUT_CLKS - 1);
    localparam logic [7:0]  MAX_LEN_B = 8'(MAX_LEN);

    logic [2:0]  state;
    logic [7:0]  len;
    logic [7:0]  sum;
    logic [7:0]  wr_idx;
    logic [7:0]  rd_idx;
    logic [23:0] to_cnt;
    logic [7:0]  pkt_buf [0:MAX_LEN-1];

    logic [7:0] len_m1;
    logic [7:0] chk_sum;
    logic       last_rd;
    logic       in_frame;

    assign len_m1   = len - 8'd1;
    assign chk_sum  = sum + i_Rx_Byte;
    assign last_rd  = (rd_idx == len_m1);
    assign in_frame = (state == s_LEN) || (state == s_PAYLOAD) || (state == s_CHK);

    // Gated so the stream reads zero whenever nothing is being offered.
    assign o_Data = o_Valid ? pkt_buf[rd_idx[IW-1:0]] : 8'h00;
    assign o_Last = o_Valid & last_rd;

    always_ff @(posedge i_Clock) begin
        if (!reset && state == s_PAYLOAD && i_Rx_DV)
            pkt_buf[wr_idx[IW-1:0]] <= i_Rx_Byte;
    end

    always_ff @(posedge i_Clock) begin
        if (reset) begin
            state         <= s_HUNT;
            len           <= 8'h00;
            sum           <= 8'h00;
            wr_idx        <= 8'h00;
            rd_idx        <= 8'h00;
            to_cnt        <= 24'h0;
            o_Receive     <= 1'b0;
            o_Valid       <= 1'b0;
            o_Pkt_Len     <= 8'h00;
            o_Busy        <= 1'b0;
            o_Err_Len     <= 1'b0;
            o_Err_Chk     <= 1'b0;
            o_Err_Timeout <= 1'b0;
        end else begin
            o_Err_Len     <= 1'b0;
            o_Err_Chk     <= 1'b0;
            o_Err_Timeout <= 1'b0;
            if (state != s_DRAIN)
                o_Receive <= 1'b1;

            // Inter-byte watchdog; an arriving byte always beats an expiring count.
            if (in_frame) begin
                if (i_Rx_DV) begin
                    to_cnt <= 24'h0;
                end else if (to_cnt == TO_LAST) begin
                    o_Err_Timeout <= 1'b1;
                    o_Busy        <= 1'b0;
                    state         <= s_HUNT;
                    to_cnt        <= 24'h0;
                end else begin
                    to_cnt <= to_cnt + 24'h1;
                end
            end

            case (state)
                s_HUNT: begin
                    if (i_Rx_DV && i_Rx_Byte == SYNC_BYTE) begin
                        state  <= s_LEN;
                        o_Busy <= 1'b1;
                        to_cnt <= 24'h0;
                    end
                end
                s_LEN: begin
                    if (i_Rx_DV) begin
                        if (i_Rx_Byte == 8'h00 || i_Rx_Byte > MAX_LEN_B) begin
                            o_Err_Len <= 1'b1;
                            o_Busy    <= 1'b0;
                            state     <= s_HUNT;
                        end else begin
                            len    <= i_Rx_Byte;
                            sum    <= i_Rx_Byte;
                            wr_idx <= 8'h00;
                            state  <= s_PAYLOAD;
                        end
                    end
                end
                s_PAYLOAD: begin
                    if (i_Rx_DV) begin
                        sum    <= chk_sum;
                        wr_idx <= wr_idx + 8'd1;
                        if (wr_idx == len_m1)
                            state <= s_CHK;
                    end
                end
                s_CHK: begin
                    if (i_Rx_DV) begin
                        if (chk_sum == 8'h00) begin
                            state     <= s_DRAIN;
                            rd_idx    <= 8'h00;
                            o_Pkt_Len <= len;
                            o_Valid   <= 1'b1;
                            o_Receive <= 1'b0;
                        end else begin
                            o_Err_Chk <= 1'b1;
                            o_Busy    <= 1'b0;
                            state     <= s_HUNT;
                        end
                    end
                end
                s_DRAIN: begin
                    if (o_Valid && i_Ready) begin
                        if (last_rd) begin
                            o_Valid   <= 1'b0;
                            o_Receive <= 1'b1;
                            o_Busy    <= 1'b0;
                            state     <= s_HUNT;
                        end else begin
                            rd_idx <= rd_idx + 8'd1;
                        end
                    end
                end
                default: state <= s_HUNT;
            endcase
        end
    end

endmodule

// File: doc/uart_rx_pkt_ctrl.md
# uart_rx_pkt_ctrl

Packet-level receive controller that sits directly above `uart_rx`. It drives `uart_rx`'s `receive` enable and consumes its byte strobes. It hunts for a sync byte, then buffers a length-prefixed, checksummed payload, and releases only verified packets on a valid/ready byte stream. While a verified packet is draining, reception is paused so no byte is overwritten.

## Interface
- SYNC_BYTE, 8'hA5, start-of-packet marker
- MAX_LEN, 16, max payload bytes (1..255); sizes internal buffer
- TIMEOUT_CLKS, 208320, max clocks between bytes inside a packet (≈2 byte times at 100 MHz/9600); must be < 2^24
- i_Clock  in  1  clock
- reset  in  1  reset, synchronous, active-high
- o_Receive  out  1  to `uart_rx` `receive`
- i_Rx_DV  in  1  from `uart_rx` `o_Rx_DV`, one-cycle byte strobe
- i_Rx_Byte  in  8  from `uart_rx` `o_Rx_Byte`
- o_Data  out  8  payload byte
- o_Valid  out  1  o_Data valid
- o_Last  out  1  final payload byte of packet
- i_Ready  in  1  consumer accepts byte
- o_Pkt_Len  out  8  payload length of packet being/last drained
- o_Busy  out  1  packet in progress (LEN/PAYLOAD/CHK/DRAIN)
- o_Err_Len  out  1  one-cycle pulse: illegal length byte
- o_Err_Chk  out  1  one-cycle pulse: checksum mismatch
- o_Err_Timeout  out  1  one-cycle pulse: inter-byte timeout

## Operation
- Frame: SYNC_BYTE, LEN, LEN payload bytes, CHK. Valid iff (LEN + Σpayload + CHK) mod 256 == 0. Sum is an 8-bit wrapping accumulator.
- States: s_HUNT, s_LEN, s_PAYLOAD, s_CHK, s_DRAIN. All transitions are evaluated only on cycles with i_Rx_DV=1, except timeout and drain.
- s_HUNT: if byte==SYNC_BYTE → s_LEN. Any other byte is discarded silently, with no error.
- s_LEN: if byte==0 or byte>MAX_LEN → pulse o_Err_Len, → s_HUNT. Otherwise latch len, sum=byte, wr_idx=0, → s_PAYLOAD.
- s_PAYLOAD: buf[wr_idx]=byte, sum+=byte, wr_idx++. When the byte just written is index len-1 → s_CHK.
- s_CHK: if (sum+byte)[7:0]==0 → s_DRAIN with rd_idx=0 and o_Pkt_Len=len. Otherwise pulse o_Err_Chk → s_HUNT.
- Timeout: a 24-bit counter runs in s_LEN/s_PAYLOAD/s_CHK. It clears on state entry from s_HUNT and on every i_Rx_DV. When it reaches TIMEOUT_CLKS-1 with no i_Rx_DV: pulse o_Err_Timeout, → s_HUNT, partial packet discarded. If i_Rx_DV and timeout occur in the same cycle, the byte wins.
- s_DRAIN: o_Valid=1, o_Data=buf[rd_idx], o_Last=(rd_idx==len-1). On o_Valid&i_Ready, rd_idx++. On the last handshake → s_HUNT.
- o_Receive: 1 in s_HUNT/s_LEN/s_PAYLOAD/s_CHK, 0 in s_DRAIN. Bytes on the line during drain are not received, by design.
- Error pulses are mutually exclusive and each lasts exactly one cycle.

## Timing
- Reset values: o_Receive=0, o_Valid=0, o_Last=0, o_Data=0, o_Pkt_Len=0, o_Busy=0, all error pulses 0, state=s_HUNT, counters 0.
- o_Receive rises on the first edge after reset deasserts.
- All outputs are registered except o_Data/o_Last. Those are a function of registered rd_idx/len and are stable while o_Valid&!i_Ready.
- The state change, o_Receive update and error pulse all occur on the edge following the i_Rx_DV cycle.
- o_Receive falls on the same edge that enters s_DRAIN. `uart_rx` is in CLEANUP at that point and therefore sees receive=0 when it returns to IDLE.
- First o_Valid is asserted on the edge following the CHK i_Rx_DV cycle.
- Drain throughput is 1 byte/clock with i_Ready held high. o_Valid drops and o_Receive rises on the edge after the last handshake.
- o_Valid never deasserts before its handshake (except reset).
- o_Pkt_Len holds its value after drain until the next verified packet.
- Reset mid-packet or mid-drain: the next edge restores all reset values, and the packet is dropped with no error pulse.

## Test plan
- Bytes A5 03 11 22 33 97 (sum 0x100) with i_Ready=1 → o_Valid for 3 consecutive cycles with data 11,22,33; o_Last on 33; o_Pkt_Len=3; no errors; o_Receive low only during drain.
- Same frame with CHK=98 → one o_Err_Chk pulse, no o_Valid, o_Receive stays 1, state back to s_HUNT.
- Bytes A5 00, then A5 11 (MAX_LEN=16) → two o_Err_Len pulses; a following valid frame is delivered correctly.
- A5 02 55 followed by silence ≥ TIMEOUT_CLKS → exactly one o_Err_Timeout pulse at TIMEOUT_CLKS-1 clocks after the 55 strobe; subsequent frame OK. A byte arriving on the timeout cycle is accepted instead.
- Valid 4-byte frame with i_Ready toggling 1/0 → each byte is held stable while stalled, 4 handshakes total, o_Last only on the 4th; garbage bytes 7E 00 before A5 are ignored silently.
- Assert reset during s_PAYLOAD and again during s_DRAIN → all outputs at reset values next edge; o_Receive=1 one edge after release; next frame delivered intact.
